// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that grants one multi-cycle resource to N requesters.
// A grant stays locked until done, owner request drop, or hold timeout.
module rr_lock_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 done_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HW  = $clog2(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;

  logic [IDW-1:0] next_ptr, sel_ptr, winner;
  logic [N-1:0]   mask, masked;
  logic           hold_at_max, owner_req, rel;

  // Lowest set index wins.
  function automatic logic [IDW-1:0] ffs(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  // While locked the next winner is chosen as if the pointer had already advanced past the owner.
  always_comb begin
    mask     = '0;
    next_ptr = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
    sel_ptr  = (state_q == LOCKED) ? next_ptr : ptr_q;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IDW'(i) >= sel_ptr);
    end
    masked = req_i & mask;
    winner = (masked != '0) ? ffs(masked) : ffs(req_i);
  end

  assign owner_req   = req_i[gnt_id_q];
  assign hold_at_max = (hold_q == HOLD_MAX);
  assign rel         = done_i | ~owner_req | hold_at_max;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          state_d  = LOCKED;
          gnt_d    = N'(1) << winner;
          gnt_id_d = winner;
          busy_d   = 1'b1;
          hold_d   = '0;
        end
      end
      LOCKED: begin
        if (!rel) begin
          hold_d = hold_q + HW'(1);
        end else begin
          ptr_d     = next_ptr;
          timeout_d = hold_at_max & ~done_i & owner_req;
          hold_d    = '0;
          if (req_i != '0) begin
            gnt_d    = N'(1) << winner;
            gnt_id_d = winner;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: directed vector table, corner sequences and a
// randomized run, all checked against a rotating-search reference model.
module tb_rr_lock_arbiter;

  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;

  logic [7:0] g16, g4;
  logic [2:0] id16, id4;
  logic       b16, b4, t16, t4;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.N(8), .MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
    .gnt_o(g16), .gnt_id_o(id16), .busy_o(b16), .timeout_o(t16));

  rr_lock_arbiter #(.N(8), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
    .gnt_o(g4), .gnt_id_o(id4), .busy_o(b4), .timeout_o(t4));

  // Reference model: owner index (-1 when idle), pointer, cycles held, timeout flag.
  typedef struct {
    int owner;
    int ptr;
    int hold;
    bit to;
  } mstate_t;

  localparam mstate_t M_RST = '{owner: -1, ptr: 0, hold: 0, to: 1'b0};

  mstate_t m16 = M_RST;
  mstate_t m4  = M_RST;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [7:0] r, input logic d, input int mh);
    mstate_t n;
    bit at_max, rel;
    n = s;
    n.to = 1'b0;
    if (s.owner < 0) begin
      if (r != 8'h00) begin
        n.owner = pick(r, s.ptr);
        n.hold  = 0;
      end
    end else begin
      at_max = (s.hold == mh - 1);
      rel    = d || !r[s.owner] || at_max;
      if (!rel) begin
        n.hold = s.hold + 1;
      end else begin
        n.to   = at_max && !d && r[s.owner];
        n.ptr  = (s.owner + 1) % NR;
        n.hold = 0;
        n.owner = (r != 8'h00) ? pick(r, n.ptr) : -1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag, input mstate_t m, input logic [7:0] g,
                             input logic [2:0] id, input logic b, input logic t);
    logic [7:0] eg;
    eg = (m.owner < 0) ? 8'h00 : (8'h01 << m.owner);
    check({tag, ".gnt"}, 32'(g), 32'(eg));
    check({tag, ".busy"}, 32'(b), 32'(m.owner >= 0));
    check({tag, ".timeout"}, 32'(t), 32'(m.to));
    if (m.owner >= 0) check({tag, ".gnt_id"}, 32'(id), 32'(m.owner));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    m16   = M_RST;
    m4    = M_RST;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply inputs across one rising edge, advance models, compare both instances.
  task automatic cycle(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    m16 = step(m16, r, d, 16);
    m4  = step(m4, r, d, 4);
    #1;
    check_model("m16", m16, g16, id16, b16, t16);
    check_model("m4", m4, g4, id4, b4, t4);
  endtask

  typedef struct {
    bit         rst;
    bit         u4;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit u4, input logic [7:0] r, input logic d,
                              input logic [7:0] g, input logic t);
    vec_t v;
    v.rst = rst; v.u4 = u4; v.req = r; v.done = d; v.gnt = g; v.to = t;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ag, r;
    logic [2:0] aid;
    logic       ab, at;
    int         eid;

    // single requester, done on the 3rd locked cycle with request dropped
    add(1, 0, 8'h04, 0, 8'h04, 0);
    add(0, 0, 8'h04, 0, 8'h04, 0);
    add(0, 0, 8'h04, 0, 8'h04, 0);
    add(0, 0, 8'h00, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 8'h00, 1, 8'h00, 0);
    // all requesting, done every second locked cycle: 0..7 then 0, no bubble
    add(1, 0, 8'hFF, 0, 8'h01, 0);
    for (int k = 0; k < 8; k++) begin
      add(0, 0, 8'hFF, 0, 8'h01 << k, 0);
      add(0, 0, 8'hFF, 1, 8'h01 << ((k + 1) % 8), 0);
    end
    // MAX_HOLD=4 timeout handoff
    add(1, 1, 8'h60, 0, 8'h20, 0);
    add(0, 1, 8'h60, 0, 8'h20, 0);
    add(0, 1, 8'h60, 0, 8'h20, 0);
    add(0, 1, 8'h60, 0, 8'h20, 0);
    add(0, 1, 8'h60, 0, 8'h40, 1);
    add(0, 1, 8'h60, 0, 8'h40, 0);
    // owner drops request; pointer moves to 4
    add(1, 0, 8'h08, 0, 8'h08, 0);
    add(0, 0, 8'h08, 0, 8'h08, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 8'hFF, 0, 8'h10, 0);
    // pointer wrap after owner 7
    add(1, 0, 8'h80, 0, 8'h80, 0);
    add(0, 0, 8'h09, 1, 8'h01, 0);
    add(0, 0, 8'h09, 1, 8'h08, 0);
    add(0, 0, 8'h09, 1, 8'h01, 0);

    do_reset();
    #1;
    check("reset.gnt", 32'(g16), 32'h0);
    check("reset.gnt_id", 32'(id16), 32'h0);
    check("reset.busy", 32'(b16), 32'h0);
    check("reset.timeout", 32'(t16), 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cycle(vecs[i].req, vecs[i].done);
      ag  = vecs[i].u4 ? g4 : g16;
      aid = vecs[i].u4 ? id4 : id16;
      ab  = vecs[i].u4 ? b4 : b16;
      at  = vecs[i].u4 ? t4 : t16;
      check($sformatf("vec%0d.gnt", i), 32'(ag), 32'(vecs[i].gnt));
      check($sformatf("vec%0d.busy", i), 32'(ab), 32'(vecs[i].gnt != 8'h00));
      check($sformatf("vec%0d.timeout", i), 32'(at), 32'(vecs[i].to));
      if (vecs[i].gnt != 8'h00) begin
        eid = 0;
        for (int b = 0; b < 8; b++) if (vecs[i].gnt[b]) eid = b;
        check($sformatf("vec%0d.gnt_id", i), 32'(aid), 32'(eid));
      end
    end

    // done coincides with the last hold cycle: released without timeout, sole owner re-granted
    do_reset();
    cycle(8'h01, 0);
    for (int k = 0; k < 15; k++) cycle(8'h01, 0);
    cycle(8'h01, 1);
    check("done_at_max.timeout", 32'(t16), 32'h0);
    check("done_at_max.gnt", 32'(g16), 32'h01);
    for (int k = 0; k < 15; k++) cycle(8'h01, 0);
    cycle(8'h01, 0);
    check("hold_timeout.timeout", 32'(t16), 32'h1);
    check("hold_timeout.gnt", 32'(g16), 32'h01);

    // asynchronous reset in the middle of a lock
    do_reset();
    cycle(8'h04, 0);
    cycle(8'h04, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.gnt16", 32'(g16), 32'h0);
    check("async_rst.busy16", 32'(b16), 32'h0);
    check("async_rst.gnt4", 32'(g4), 32'h0);
    check("async_rst.busy4", 32'(b4), 32'h0);
    m16 = M_RST;
    m4  = M_RST;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h06, 0);
    check("after_rst.gnt", 32'(g16), 32'h02);

    // randomized traffic against the model
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 8'h00;
          1: r = 8'hFF;
          2: r = 8'h01 << $urandom_range(0, 7);
          default: r = 8'($urandom);
        endcase
      end
      cycle(r, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
